// File: rtl/frv_fetch_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frv_fetch_buffer_if                                                       |
// | Memory-response push side and decode-side valid/busy handshake.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface frv_fetch_buffer_if;
   logic        flush;
   logic [31:0] i_data;
   logic        i_err;
   logic        i_half;
   logic        i_valid;
   logic        o_busy;
   logic [31:0] o_data;
   logic        o_len32;
   logic        o_err;
   logic        o_valid;
   logic        i_busy;

   modport slave (
      input  flush, i_data, i_err, i_half, i_valid, i_busy,
      output o_busy, o_data, o_len32, o_err, o_valid
   );

   modport master (
      output flush, i_data, i_err, i_half, i_valid, i_busy,
      input  o_busy, o_data, o_len32, o_err, o_valid
   );
endinterface
`default_nettype wire

// File: rtl/frv_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frv_fetch_buffer                                                          |
// | Halfword realignment buffer presenting whole 16/32-bit instructions.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module frv_fetch_buffer #(
   parameter int BUF_HW = 4
) (
   input  wire logic         g_clk,
   input  wire logic         g_resetn,
   frv_fetch_buffer_if.slave fb
);

   localparam int c_cnt_w = $clog2(BUF_HW + 1);
   localparam int c_vec_w = 16 * BUF_HW;
   localparam logic [c_cnt_w-1:0] c_zero     = c_cnt_w'(0);
   localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_two      = c_cnt_w'(2);
   localparam logic [c_cnt_w-1:0] c_busy_lvl = c_cnt_w'(BUF_HW - 2);

   // Slots packed into one vector, slot 0 (oldest) in the low 16 bits.
   logic [c_cnt_w-1:0] r_count;
   logic [c_vec_w-1:0] r_hw;
   logic [BUF_HW-1:0]  r_err;

   logic               w_len32;
   logic               w_valid;
   logic               w_busy;
   logic               w_pop;
   logic               w_push;
   logic [c_cnt_w-1:0] w_pop_n;
   logic [c_cnt_w-1:0] w_push_n;
   logic [c_cnt_w-1:0] w_base;
   logic [c_vec_w-1:0] w_push_hw;
   logic [BUF_HW-1:0]  w_push_err;
   logic [c_vec_w-1:0] w_hw_nxt;
   logic [BUF_HW-1:0]  w_err_nxt;
   logic [c_cnt_w-1:0] w_count_nxt;

   // A faulted slot 0 is never treated as the start of a 32-bit pair.
   assign w_len32 = (r_hw[1:0] == 2'b11) && !r_err[0];
   assign w_valid = (r_count >= c_two) || ((r_count == c_one) && !w_len32);
   assign w_busy  = (r_count > c_busy_lvl);

   assign fb.o_valid = w_valid;
   assign fb.o_busy  = w_busy;
   assign fb.o_len32 = w_len32;
   assign fb.o_data  = w_len32 ? r_hw[31:0] : {16'h0000, r_hw[15:0]};
   assign fb.o_err   = r_err[0] | (w_len32 & r_err[1]);

   assign w_pop  = w_valid && !fb.i_busy;
   assign w_push = fb.i_valid && !w_busy;

   always_comb begin
      w_pop_n    = c_zero;
      w_push_n   = c_zero;
      w_push_hw  = '0;
      w_push_err = '0;
      if (w_pop) begin
         w_pop_n = w_len32 ? c_two : c_one;
      end
      if (w_push) begin
         if (fb.i_half) begin
            w_push_n   = c_one;
            w_push_hw  = {{(c_vec_w-16){1'b0}}, fb.i_data[31:16]};
            w_push_err = {{(BUF_HW-1){1'b0}}, fb.i_err};
         end else begin
            w_push_n   = c_two;
            w_push_hw  = {{(c_vec_w-32){1'b0}}, fb.i_data};
            w_push_err = {{(BUF_HW-2){1'b0}}, fb.i_err, fb.i_err};
         end
      end
      // Shift out popped slots, clear everything at and above the append
      // point (stale after a flush), then drop the new halfwords in there.
      w_base      = r_count - w_pop_n;
      w_hw_nxt    = ((r_hw >> {w_pop_n, 4'b0000})
                    & ~({c_vec_w{1'b1}} << {w_base, 4'b0000}))
                    | (w_push_hw << {w_base, 4'b0000});
      w_err_nxt   = ((r_err >> w_pop_n) & ~({BUF_HW{1'b1}} << w_base))
                    | (w_push_err << w_base);
      w_count_nxt = w_base + w_push_n;
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_count <= '0;
         r_hw    <= '0;
         r_err   <= '0;
      end else if (fb.flush) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
         r_hw    <= w_hw_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule
`default_nettype wire
